// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronizes the raw pins, deframes 11-bit frames and
// folds E0/F0 prefixes into a single key event with extended/break flags.
module ps2_key_receiver #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] scan_code_o,
  output logic       break_o,
  output logic       extended_o,
  output logic       key_valid_o,
  output logic       frame_error_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  logic       clk1_q, clk2_q, clk3_q;
  logic       dat1_q, dat2_q;
  logic [1:0] live_q;
  logic       armed_q;
  logic       edge_s;

  state_e     state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic       acc_q, acc_d;
  logic       err_q, err_d;
  logic       tmo_fire;

  logic       ext_pend_q, brk_pend_q;
  logic [7:0] scan_q;
  logic       brk_q, ext_q, kv_q, fe_q;

  // live_q marks when clk2_q holds a real pin sample, so reset values never arm the edge detector
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk1_q  <= 1'b1;
      clk2_q  <= 1'b1;
      clk3_q  <= 1'b1;
      dat1_q  <= 1'b1;
      dat2_q  <= 1'b1;
      live_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      clk1_q  <= ps2_clk_i;
      clk2_q  <= clk1_q;
      clk3_q  <= clk2_q;
      dat1_q  <= ps2_data_i;
      dat2_q  <= dat1_q;
      live_q  <= {live_q[0], 1'b1};
      armed_q <= armed_q | (live_q[1] & clk2_q);
    end
  end

  assign edge_s = armed_q & clk3_q & ~clk2_q;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    acc_d    = 1'b0;
    err_d    = 1'b0;
    tmo_fire = 1'b0;
    if (state_q == IDLE || edge_s) tmo_d = '0;
    else                           tmo_d = tmo_q + TW'(1);

    if (state_q != IDLE && !edge_s && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      tmo_fire = 1'b1;
      state_d  = IDLE;
      tmo_d    = '0;
    end else if (edge_s) begin
      case (state_q)
        IDLE: begin
          if (!dat2_q) begin
            state_d  = DATA;
            bitcnt_d = 3'd0;
          end
        end
        DATA: begin
          shift_d  = {dat2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat2_q;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (dat2_q && (^{shift_q, par_q})) acc_d = 1'b1;
          else                               err_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      bitcnt_q <= 3'd0;
      shift_q  <= 8'h00;
      par_q    <= 1'b0;
      tmo_q    <= '0;
      acc_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tmo_q    <= tmo_d;
      acc_q    <= acc_d;
      err_q    <= err_d;
    end
  end

  // Output stage: a timeout fires directly, frame results arrive one cycle after the stop edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      scan_q     <= 8'h00;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      kv_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      kv_q <= 1'b0;
      fe_q <= 1'b0;
      if (err_q || tmo_fire) begin
        fe_q       <= 1'b1;
        ext_pend_q <= 1'b0;
        brk_pend_q <= 1'b0;
      end else if (acc_q) begin
        if (shift_q == 8'hE0) begin
          ext_pend_q <= 1'b1;
        end else if (shift_q == 8'hF0) begin
          brk_pend_q <= 1'b1;
        end else begin
          scan_q     <= shift_q;
          brk_q      <= brk_pend_q;
          ext_q      <= ext_pend_q;
          kv_q       <= 1'b1;
          ext_pend_q <= 1'b0;
          brk_pend_q <= 1'b0;
        end
      end
    end
  end

  assign scan_code_o   = scan_q;
  assign break_o       = brk_q;
  assign extended_o    = ext_q;
  assign key_valid_o   = kv_q;
  assign frame_error_o = fe_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Scoreboard bench for ps2_key_receiver: a byte-level key-event model predicts
// every pulse and its cycle; a monitor pops and compares whenever the DUT pulses.
module tb_ps2_key_receiver;
  localparam int T  = 300;
  localparam int HB = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] scan;
  logic       brk, ext, kv, fe;

  ps2_key_receiver #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ps2_clk_i    (ps2_clk),
    .ps2_data_i   (ps2_dat),
    .scan_code_o  (scan),
    .break_o      (brk),
    .extended_o   (ext),
    .key_valid_o  (kv),
    .frame_error_o(fe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit       err;
    bit [7:0] code;
    bit       brk;
    bit       ext;
    int       cyc;
  } exp_t;

  exp_t exp_q[$];
  bit   m_brk = 1'b0;
  bit   m_ext = 1'b0;
  int   last_fall = 0;
  bit   done = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Key-event model: prefixes accumulate, any other good byte emits and clears, any error clears
  function automatic void push_err(input int c);
    exp_t e;
    e.err = 1'b1; e.code = 8'h00; e.brk = 1'b0; e.ext = 1'b0; e.cyc = c;
    exp_q.push_back(e);
    m_brk = 1'b0;
    m_ext = 1'b0;
  endfunction

  function automatic void model_byte(input bit [7:0] b, input bit ok, input int c);
    exp_t e;
    if (!ok) push_err(c);
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      e.err = 1'b0; e.code = b; e.brk = m_brk; e.ext = m_ext; e.cyc = c;
      exp_q.push_back(e);
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endfunction

  task automatic bit_fall(input bit d);
    ps2_dat = d;
    repeat (HB) @(negedge clk);
    ps2_clk   = 1'b0;
    last_fall = cyc;
  endtask

  task automatic bit_rise();
    repeat (HB) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input bit [7:0] b, input bit bad_par, input bit bad_stop);
    bit p;
    bit_fall(1'b0); bit_rise();
    for (int i = 0; i < 8; i++) begin
      bit_fall(b[i]); bit_rise();
    end
    p = (~^b) ^ bad_par;
    bit_fall(p); bit_rise();
    bit_fall(~bad_stop);
    model_byte(b, !bad_par && !bad_stop, last_fall + 4);
    bit_rise();
    ps2_dat = 1'b1;
  endtask

  task automatic send_partial(input int nbits);
    bit_fall(1'b0); bit_rise();
    for (int i = 0; i < nbits; i++) begin
      bit_fall(1'($urandom_range(0, 1))); bit_rise();
    end
    ps2_dat = 1'b1;
    push_err(last_fall + 3 + T);
    repeat (T + 40) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    m_brk = 1'b0;
    m_ext = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        check("leftover_expected", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
      if (!rst_n) begin
        check("rst_scan", scan, 0);
        check("rst_break", brk, 0);
        check("rst_ext", ext, 0);
        check("rst_valid", kv, 0);
        check("rst_ferr", fe, 0);
      end else if (kv || fe) begin
        check("valid_ferr_exclusive", kv & fe, 0);
        if (exp_q.size() == 0) begin
          check("pulse_expected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind_ferr", fe, e.err);
          check("pulse_cycle", cyc, e.cyc);
          if (!e.err) begin
            check("scan_code", scan, e.code);
            check("break", brk, e.brk);
            check("extended", ext, e.ext);
          end
        end
      end
    end
  end

  initial begin : stimulus
    bit [7:0] b;
    bit       bp, bs;
    int       sel;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h74, 1'b0, 1'b0);
    send_frame(8'h74, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h12, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1);
    send_partial(5);
    send_frame(8'h29, 1'b0, 1'b0);

    // Abort a frame with reset after four data bits
    send_frame(8'hF0, 1'b0, 1'b0);
    bit_fall(1'b0); bit_rise();
    for (int i = 0; i < 4; i++) begin
      bit_fall(1'b1); bit_rise();
    end
    ps2_dat = 1'b1;
    pulse_reset();
    send_frame(8'h1C, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        send_partial($urandom_range(0, 9));
      end else begin
        sel = $urandom_range(0, 5);
        b   = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom);
        bp  = ($urandom_range(0, 9) == 0);
        bs  = !bp && ($urandom_range(0, 9) == 0);
        send_frame(b, bp, bs);
      end
      repeat ($urandom_range(5, 40)) @(negedge clk);
    end

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    done = 1'b1;
  end
endmodule
